// File: rtl/core_pkg.sv
// Shared core definitions: mcause exception codes and the trap sequencer state encoding.
package core_pkg;

    // Exception codes; the interrupt flag (mcause MSB) is added by the priority encoder.
    localparam int CAUSE_ILLEGAL     = 2;
    localparam int CAUSE_EBREAK      = 3;
    localparam int CAUSE_MISALIGN_LD = 4;
    localparam int CAUSE_TIMER_IRQ   = 7;
    localparam int CAUSE_ECALL_M     = 11;
    localparam int CAUSE_EXT_IRQ     = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_COMMIT,
        ST_REDIRECT
    } trap_state_t;

endpackage

// File: rtl/trap_priority_enc.sv
// Combinational trap source prioritiser: picks the winning exception/interrupt/mret
// for the instruction in execute and produces its mcause value.
module trap_priority_enc
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            instr_valid,
    input  logic            ecall,
    input  logic            ebreak,
    input  logic            illegal,
    input  logic            misalign_ld,
    input  logic            mret,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic            mie,
    output logic            valid,
    output logic            is_ret,
    output logic [XLEN-1:0] cause
);

    always_comb begin
        valid  = 1'b0;
        is_ret = 1'b0;
        cause  = '0;
        // Interrupts only compete when globally enabled; otherwise fall through to exceptions.
        if (instr_valid) begin
            if (ext_irq && mie) begin
                valid = 1'b1;
                cause = {1'b1, (XLEN-1)'(CAUSE_EXT_IRQ)};
            end else if (timer_irq && mie) begin
                valid = 1'b1;
                cause = {1'b1, (XLEN-1)'(CAUSE_TIMER_IRQ)};
            end else if (illegal) begin
                valid = 1'b1;
                cause = XLEN'(CAUSE_ILLEGAL);
            end else if (ebreak) begin
                valid = 1'b1;
                cause = XLEN'(CAUSE_EBREAK);
            end else if (misalign_ld) begin
                valid = 1'b1;
                cause = XLEN'(CAUSE_MISALIGN_LD);
            end else if (ecall) begin
                valid = 1'b1;
                cause = XLEN'(CAUSE_ECALL_M);
            end else if (mret) begin
                valid  = 1'b1;
                is_ret = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry / mret sequencer: IDLE -> FLUSH -> COMMIT -> REDIRECT -> IDLE,
// stalling and flushing the pipeline and strobing the CSR block and fetch redirect.
module trap_controller
    import core_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] Di_PC,
    input  logic            Di_instrValid,
    input  logic            Di_ecall,
    input  logic            Di_ebreak,
    input  logic            Di_illegal,
    input  logic            Di_misalignLd,
    input  logic            Di_mret,
    input  logic            Di_extIrq,
    input  logic            Di_timerIrq,
    input  logic            Di_mstatusMIE,
    input  logic [XLEN-1:0] Di_mtvec,
    input  logic [XLEN-1:0] Di_mepc,
    output logic            Do_stall,
    output logic            Do_flush,
    output logic            Do_trapCommit,
    output logic            Do_retCommit,
    output logic [XLEN-1:0] Do_trapEpc,
    output logic [XLEN-1:0] Do_trapCause,
    output logic            Do_redirect,
    output logic [XLEN-1:0] Do_redirectPC
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

    trap_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            is_ret_q, is_ret_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;

    logic            enc_valid;
    logic            enc_is_ret;
    logic [XLEN-1:0] enc_cause;

    trap_priority_enc #(
        .XLEN(XLEN)
    ) u_prio (
        .instr_valid(Di_instrValid),
        .ecall      (Di_ecall),
        .ebreak     (Di_ebreak),
        .illegal    (Di_illegal),
        .misalign_ld(Di_misalignLd),
        .mret       (Di_mret),
        .ext_irq    (Di_extIrq),
        .timer_irq  (Di_timerIrq),
        .mie        (Di_mstatusMIE),
        .valid      (enc_valid),
        .is_ret     (enc_is_ret),
        .cause      (enc_cause)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            is_ret_q <= 1'b0;
            cause_q  <= '0;
            epc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_ret_q <= is_ret_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_ret_d      = is_ret_q;
        cause_d       = cause_q;
        epc_d         = epc_q;
        Do_stall      = 1'b0;
        Do_flush      = 1'b0;
        Do_trapCommit = 1'b0;
        Do_retCommit  = 1'b0;
        Do_trapEpc    = '0;
        Do_trapCause  = '0;
        Do_redirect   = 1'b0;
        Do_redirectPC = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_d  = ST_FLUSH;
                    cnt_d    = '0;
                    is_ret_d = enc_is_ret;
                    cause_d  = enc_cause;
                    epc_d    = Di_PC;
                end
            end
            ST_FLUSH: begin
                Do_stall = 1'b1;
                Do_flush = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                Do_stall = 1'b1;
                if (is_ret_q) begin
                    Do_retCommit = 1'b1;
                end else begin
                    Do_trapCommit = 1'b1;
                    Do_trapEpc    = epc_q;
                    Do_trapCause  = cause_q;
                end
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                // Vector/mepc are read here, one cycle after COMMIT, so the CSR update is visible.
                Do_stall      = 1'b1;
                Do_redirect   = 1'b1;
                Do_redirectPC = is_ret_q ? Di_mepc : (Di_mtvec & ~(XLEN'(3)));
                cnt_d         = '0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench: three trap_controller builds (FLUSH_CYCLES 1/2/4) on shared stimulus,
// checked against a timeline reference model plus directed vectors and sequences.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] di_pc, di_mtvec, di_mepc;
    logic        di_valid, di_ecall, di_ebreak, di_illegal, di_mis, di_mret;
    logic        di_ext, di_tmr, di_mie;

    logic [2:0]  o_stall, o_flush, o_tc, o_rc, o_rd;
    logic [31:0] o_epc [3];
    logic [31:0] o_cause [3];
    logic [31:0] o_rpc [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic int fs(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        trap_controller #(
            .FLUSH_CYCLES((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
            .XLEN        (32)
        ) dut (
            .clk          (clk),
            .reset        (reset),
            .Di_PC        (di_pc),
            .Di_instrValid(di_valid),
            .Di_ecall     (di_ecall),
            .Di_ebreak    (di_ebreak),
            .Di_illegal   (di_illegal),
            .Di_misalignLd(di_mis),
            .Di_mret      (di_mret),
            .Di_extIrq    (di_ext),
            .Di_timerIrq  (di_tmr),
            .Di_mstatusMIE(di_mie),
            .Di_mtvec     (di_mtvec),
            .Di_mepc      (di_mepc),
            .Do_stall     (o_stall[g]),
            .Do_flush     (o_flush[g]),
            .Do_trapCommit(o_tc[g]),
            .Do_retCommit (o_rc[g]),
            .Do_trapEpc   (o_epc[g]),
            .Do_trapCause (o_cause[g]),
            .Do_redirect  (o_rd[g]),
            .Do_redirectPC(o_rpc[g])
        );
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Source bits: {valid, ext, tmr, mie, ill, ebk, mis, ecall, mret}
    task automatic apply_stimulus(input logic [8:0] src, input logic [31:0] pc);
        @(posedge clk);
        #1;
        {di_valid, di_ext, di_tmr, di_mie, di_illegal, di_ebreak, di_mis, di_ecall, di_mret} = src;
        di_pc = pc;
    endtask

    // Reference priority written straight from the ranking of trap sources.
    function automatic void ref_event(input logic [8:0] src, output bit ev, output bit ret,
                                      output logic [31:0] cause);
        bit v, ext, tmr, mie, ill, ebk, mis, ecl, mrt;
        {v, ext, tmr, mie, ill, ebk, mis, ecl, mrt} = src;
        ev = 1'b1; ret = 1'b0; cause = 32'h0;
        if (!v)              ev = 1'b0;
        else if (ext && mie) cause = 32'h8000000B;
        else if (tmr && mie) cause = 32'h80000007;
        else if (ill)        cause = 32'd2;
        else if (ebk)        cause = 32'd3;
        else if (mis)        cause = 32'd4;
        else if (ecl)        cause = 32'd11;
        else if (mrt)        ret = 1'b1;
        else                 ev = 1'b0;
    endfunction

    // Timeline model: offset counts cycles since the accept edge (1..F+2).
    bit          m_active [3];
    int          m_off [3];
    bit          m_ret [3];
    logic [31:0] m_cause [3];
    logic [31:0] m_epc [3];

    always @(negedge clk) begin
        bit e_fl, e_tc, e_rc, e_rd, ev, ret;
        logic [31:0] cause;
        for (int k = 0; k < 3; k++) begin
            if (chk_en) begin
                e_fl = m_active[k] && (m_off[k] <= fs(k));
                e_tc = m_active[k] && (m_off[k] == fs(k) + 1) && !m_ret[k];
                e_rc = m_active[k] && (m_off[k] == fs(k) + 1) && m_ret[k];
                e_rd = m_active[k] && (m_off[k] == fs(k) + 2);
                check_output($sformatf("dut%0d_stall", k), 32'(o_stall[k]), 32'(m_active[k]));
                check_output($sformatf("dut%0d_flush", k), 32'(o_flush[k]), 32'(e_fl));
                check_output($sformatf("dut%0d_trapCommit", k), 32'(o_tc[k]), 32'(e_tc));
                check_output($sformatf("dut%0d_retCommit", k), 32'(o_rc[k]), 32'(e_rc));
                check_output($sformatf("dut%0d_redirect", k), 32'(o_rd[k]), 32'(e_rd));
                if (e_tc) begin
                    check_output($sformatf("dut%0d_epc", k), o_epc[k], m_epc[k]);
                    check_output($sformatf("dut%0d_cause", k), o_cause[k], m_cause[k]);
                end
                if (e_rd)
                    check_output($sformatf("dut%0d_redirectPC", k), o_rpc[k],
                                 m_ret[k] ? di_mepc : (di_mtvec & 32'hFFFF_FFFC));
            end
            if (reset) begin
                m_active[k] = 1'b0;
            end else if (m_active[k]) begin
                if (m_off[k] == fs(k) + 2) m_active[k] = 1'b0;
                else m_off[k]++;
            end else begin
                ref_event({di_valid, di_ext, di_tmr, di_mie, di_illegal, di_ebreak, di_mis,
                           di_ecall, di_mret}, ev, ret, cause);
                if (ev) begin
                    m_active[k] = 1'b1;
                    m_off[k]    = 1;
                    m_ret[k]    = ret;
                    m_cause[k]  = cause;
                    m_epc[k]    = di_pc;
                end
            end
        end
    end

    typedef struct {
        logic [8:0]  src;
        logic [31:0] pc;
        bit          exp_ev;
        bit          exp_ret;
        logic [31:0] exp_cause;
    } vec_t;

    localparam logic [8:0] IDLE_SRC = 9'b1_0000_0000;

    initial begin
        vec_t vecs [12];
        int   got_n, n_tc, n_strobe;
        int   rd_n [3];
        int   fl_n [3];
        logic [31:0] got_cause, got_epc;
        bit   got_ret;

        vecs[0]  = '{9'b100000010, 32'h100, 1'b1, 1'b0, 32'd11};
        vecs[1]  = '{9'b100001000, 32'h104, 1'b1, 1'b0, 32'd3};
        vecs[2]  = '{9'b100010000, 32'h108, 1'b1, 1'b0, 32'd2};
        vecs[3]  = '{9'b100000100, 32'h10C, 1'b1, 1'b0, 32'd4};
        vecs[4]  = '{9'b100000001, 32'h110, 1'b1, 1'b1, 32'd0};
        vecs[5]  = '{9'b111110000, 32'h080, 1'b1, 1'b0, 32'h8000000B};
        vecs[6]  = '{9'b111010000, 32'h080, 1'b1, 1'b0, 32'd2};
        vecs[7]  = '{9'b101101000, 32'h114, 1'b1, 1'b0, 32'h80000007};
        vecs[8]  = '{9'b100000011, 32'h118, 1'b1, 1'b0, 32'd11};
        vecs[9]  = '{9'b000000010, 32'h11C, 1'b0, 1'b0, 32'd0};
        vecs[10] = '{9'b110000001, 32'h120, 1'b1, 1'b1, 32'd0};
        vecs[11] = '{9'b100000110, 32'h124, 1'b1, 1'b0, 32'd4};

        reset = 1'b1;
        {di_valid, di_ext, di_tmr, di_mie, di_illegal, di_ebreak, di_mis, di_ecall, di_mret} = '0;
        di_pc = '0; di_mtvec = 32'h0000_0207; di_mepc = 32'h0000_0104;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check_output($sformatf("reset_dut%0d_outputs", k),
                         32'({o_stall[k], o_flush[k], o_tc[k], o_rc[k], o_rd[k]}) |
                         o_epc[k] | o_cause[k] | o_rpc[k], 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single-cycle vectors, observed on the FLUSH_CYCLES=2 build (commit expected at offset 3).
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].src, vecs[i].pc);
            apply_stimulus(IDLE_SRC, 32'h0);
            got_n = 0; got_ret = 1'b0; got_cause = '0; got_epc = '0;
            for (int n = 1; n <= 8; n++) begin
                @(negedge clk);
                if ((o_tc[1] || o_rc[1]) && got_n == 0) begin
                    got_n = n; got_ret = o_rc[1]; got_cause = o_cause[1]; got_epc = o_epc[1];
                end
            end
            check_output($sformatf("vec%0d_commit_seen", i), 32'(got_n != 0), 32'(vecs[i].exp_ev));
            if (vecs[i].exp_ev) begin
                check_output($sformatf("vec%0d_commit_offset", i), got_n, 32'd3);
                check_output($sformatf("vec%0d_is_ret", i), 32'(got_ret), 32'(vecs[i].exp_ret));
                if (!vecs[i].exp_ret) begin
                    check_output($sformatf("vec%0d_cause", i), got_cause, vecs[i].exp_cause);
                    check_output($sformatf("vec%0d_epc", i), got_epc, vecs[i].pc);
                end
            end
        end

        // ecall with mtvec low bits set: flush width and redirect offset per build.
        di_mtvec = 32'h0000_0207;
        apply_stimulus(9'b100000010, 32'h100);
        apply_stimulus(IDLE_SRC, 32'h0);
        for (int k = 0; k < 3; k++) begin rd_n[k] = 0; fl_n[k] = 0; end
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (o_flush[k]) fl_n[k]++;
                if (o_rd[k] && rd_n[k] == 0) begin
                    rd_n[k] = n;
                    check_output($sformatf("ecall_dut%0d_redirectPC", k), o_rpc[k], 32'h204);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("ecall_dut%0d_flush_width", k), fl_n[k], fs(k));
            check_output($sformatf("ecall_dut%0d_redirect_offset", k), rd_n[k], fs(k) + 2);
        end

        // mret: retCommit then redirect to mepc, never a trap commit.
        di_mepc = 32'h0000_0104;
        apply_stimulus(9'b100000001, 32'h200);
        apply_stimulus(IDLE_SRC, 32'h0);
        n_tc = 0; got_n = 0; rd_n[1] = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (o_tc[1]) n_tc++;
            if (o_rc[1] && got_n == 0) got_n = n;
            if (o_rd[1] && rd_n[1] == 0) begin
                rd_n[1] = n;
                check_output("mret_redirectPC", o_rpc[1], 32'h104);
            end
        end
        check_output("mret_trapCommit_count", n_tc, 32'd0);
        check_output("mret_retCommit_offset", got_n, 32'd3);
        check_output("mret_redirect_offset", rd_n[1], 32'd4);

        // ecall accepted, then illegal during FLUSH must be ignored.
        apply_stimulus(9'b100000010, 32'h300);
        apply_stimulus(9'b100010000, 32'h304);
        apply_stimulus(IDLE_SRC, 32'h0);
        n_tc = 0; got_cause = '0;
        for (int n = 2; n <= 9; n++) begin
            @(negedge clk);
            if (o_tc[1]) begin n_tc++; got_cause = o_cause[1]; end
        end
        check_output("flush_ignore_commit_count", n_tc, 32'd1);
        check_output("flush_ignore_cause", got_cause, 32'd11);

        // Reset in the middle of FLUSH: outputs clear on the next edge, no strobe afterwards.
        apply_stimulus(9'b100000010, 32'h400);
        apply_stimulus(IDLE_SRC, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_output("midflush_dut2_flush_before_reset_edge", 32'(o_flush[2]), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check_output($sformatf("midflush_reset_dut%0d_outputs", k),
                         32'({o_stall[k], o_flush[k], o_tc[k], o_rc[k], o_rd[k]}) |
                         o_epc[k] | o_cause[k] | o_rpc[k], 32'd0);
        n_strobe = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            n_strobe += $countones({o_tc, o_rc, o_rd});
        end
        check_output("midflush_no_strobe_after_reset", n_strobe, 32'd0);

        // Randomised traffic, checked cycle by cycle against the timeline model.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            reset      = ($urandom_range(0, 49) == 0);
            di_valid   = ($urandom_range(0, 3) != 0);
            di_ext     = ($urandom_range(0, 9) == 0);
            di_tmr     = ($urandom_range(0, 9) == 0);
            di_mie     = $urandom_range(0, 1) == 1;
            di_illegal = ($urandom_range(0, 9) == 0);
            di_ebreak  = ($urandom_range(0, 9) == 0);
            di_mis     = ($urandom_range(0, 9) == 0);
            di_ecall   = ($urandom_range(0, 9) == 0);
            di_mret    = ($urandom_range(0, 9) == 0);
            di_pc      = $urandom;
            di_mtvec   = $urandom;
            di_mepc    = $urandom;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        {di_valid, di_ext, di_tmr, di_mie, di_illegal, di_ebreak, di_mis, di_ecall, di_mret} = IDLE_SRC;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
